// File: rtl/load_align_unit.sv
// Registered load-data aligner: extracts the addressed B/H/W/D lane and sign/zero-extends it.
// Define LOAD_UNALIGNED_EN to merge word-crossing loads over two beats instead of faulting.
module load_align_unit #(
  parameter int unsigned PROC_BITS = 32,
  localparam int unsigned WORD_BYTES = PROC_BITS / 8,
  localparam int unsigned OFS_BITS = $clog2(WORD_BYTES)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PROC_BITS-1:0] i_data_in,
  input  logic [OFS_BITS-1:0]  i_byte_offset,
  input  logic [2:0]           i_ls_filter_op,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PROC_BITS-1:0] o_data_out,
  output logic                 o_misaligned,
  output logic                 o_beat2_pending
);

  localparam int unsigned ShW = OFS_BITS + 3;

  // Codes with no defined lane at this width pass the word through untouched.
  function automatic logic is_pass(input logic [2:0] op);
    return (op == 3'b010) || ((PROC_BITS == 32) && (op[2:1] == 2'b11));
  endfunction

  function automatic logic [3:0] op_size(input logic [2:0] op);
    logic [3:0] sz;
    case (op)
      3'b000, 3'b100: sz = 4'd1;
      3'b001, 3'b101: sz = 4'd2;
      3'b011, 3'b110: sz = 4'd4;
      3'b111:         sz = 4'd8;
      default:        sz = 4'(WORD_BYTES);
    endcase
    if (is_pass(op)) sz = 4'(WORD_BYTES);
    return sz;
  endfunction

  function automatic logic [PROC_BITS-1:0] extend(input logic [PROC_BITS-1:0] raw,
                                                  input logic [3:0]           sz,
                                                  input logic                 sgn);
    logic [PROC_BITS-1:0] ext;
    logic                 fill;
    case (sz)
      4'd1:    fill = sgn & raw[7];
      4'd2:    fill = sgn & raw[15];
      4'd4:    fill = sgn & raw[31];
      default: fill = sgn & raw[PROC_BITS-1];
    endcase
    for (int i = 0; i < PROC_BITS; i++) begin
      ext[i] = (i < 8 * int'(sz)) ? raw[i] : fill;
    end
    return ext;
  endfunction

  logic                 accept;
  logic                 valid_q, valid_d;
  logic                 mis_q, mis_d;
  logic [PROC_BITS-1:0] data_q, data_d;
  logic [3:0]           ofs4;
  logic [3:0]           cur_size;
  logic                 cur_pass;
  logic [PROC_BITS-1:0] lane;

  assign o_ready  = !valid_q || i_ready;
  assign accept   = i_valid && o_ready;
  assign ofs4     = 4'(i_byte_offset);
  assign cur_size = op_size(i_ls_filter_op);
  assign cur_pass = is_pass(i_ls_filter_op);
  assign lane     = cur_pass ? i_data_in : (i_data_in >> {i_byte_offset, 3'b000});

`ifdef LOAD_UNALIGNED_EN
  typedef enum logic [0:0] {StIdle, StBeat2} state_e;

  localparam logic [ShW:0] ProcBitsW = PROC_BITS[ShW:0];

  state_e               state_q, state_d;
  logic [PROC_BITS-1:0] hold_q, hold_d;
  logic [2:0]           op_q, op_d;
  logic [OFS_BITS-1:0]  ofs_q, ofs_d;
  logic                 crosses;
  logic [ShW:0]         sh2;

  assign crosses = !cur_pass && (({1'b0, ofs4} + {1'b0, cur_size}) > 5'(WORD_BYTES));
  // Beat-1 bytes already sit at the bottom of hold_q; beat-2 bytes go directly above them.
  assign sh2     = ProcBitsW - {1'b0, ofs_q, 3'b000};
  assign o_beat2_pending = (state_q == StBeat2);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    op_d    = op_q;
    ofs_d   = ofs_q;
    valid_d = valid_q;
    data_d  = data_q;
    mis_d   = 1'b0;
    if (accept) begin
      if (state_q == StBeat2) begin
        valid_d = 1'b1;
        data_d  = extend(hold_q | (i_data_in << sh2), op_size(op_q), !op_q[2]);
        state_d = StIdle;
      end else if (crosses) begin
        // An accept implies the output was empty or draining, so no result is lost here.
        valid_d = 1'b0;
        hold_d  = lane;
        op_d    = i_ls_filter_op;
        ofs_d   = i_byte_offset;
        state_d = StBeat2;
      end else begin
        valid_d = 1'b1;
        data_d  = extend(lane, cur_size, !i_ls_filter_op[2]);
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      op_q    <= '0;
      ofs_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      ofs_q   <= ofs_d;
    end
  end
`else
  logic fault;

  assign fault = !cur_pass && ((ofs4 & (cur_size - 4'd1)) != 4'd0);
  assign o_beat2_pending = 1'b0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mis_d   = mis_q;
    if (accept) begin
      valid_d = 1'b1;
      mis_d   = fault;
      data_d  = fault ? '0 : extend(lane, cur_size, !i_ls_filter_op[2]);
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data_out   = data_q;
  assign o_misaligned = mis_q;

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Registered, parametrised load-data aligner for the memory stage. It takes the raw memory read word, the low address bits and the load filter op, extracts the addressed byte/half/word/double lane, and sign- or zero-extends it. A valid/ready handshake and a one-deep output register connect it to the write-back path. A compile-time option adds two-beat handling of loads that cross a word boundary.

## Interface
- `PROC_BITS`, 32, datapath width; legal values 32 or 64. `WORD_BYTES = PROC_BITS/8`; `OFS_BITS = log2(WORD_BYTES)`.
- `i_clock`  in  1  single clock; all state on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  unit accepts a beat this cycle.
- `i_data_in`  in  PROC_BITS  memory read word, little-endian; byte k = bits [8k+7:8k].
- `i_byte_offset`  in  OFS_BITS  address low bits of the load.
- `i_ls_filter_op`  in  3  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU, 110 LWU (64 only), 111 LD (64 only).
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts result.
- `o_data_out`  out  PROC_BITS  extended result.
- `o_misaligned`  out  1  result is a misaligned-access fault; qualified by `o_valid`.
- `o_beat2_pending`  out  1  first beat of a crossing load held; next accepted beat is its second word.

## Operation
- Access size: B=1, H=2, W=4, D=8 bytes. Codes 110/111 at PROC_BITS=32 and code 010 at either width: pass `i_data_in` unchanged, size treated as full word, no fault.
- Extraction: lane = `size` bytes starting at byte `i_byte_offset`. Signed ops replicate the lane MSB; unsigned ops fill with 0. LW at 64 sign-extends from bit 31.
- Alignment rule (macro off): fault when `i_byte_offset mod size != 0`. A fault produces `o_data_out = 0`, `o_misaligned = 1`, single beat.
- Accept: beat accepted when `i_valid && o_ready`. `o_ready = !o_valid || i_ready`, forced to 1 in BEAT2 when `o_valid` is 0.
- FSM: IDLE, BEAT2. BEAT2 exists only with the macro. With the macro off, the unit stays in IDLE.
- Output register: loaded on accept, except on a first beat that enters BEAT2. Holds its value while `o_valid && !i_ready`.

## Timing
- Reset values: `o_valid = 0`, `o_data_out = 0`, `o_misaligned = 0`, `o_beat2_pending = 0`, state IDLE. Reset is asynchronous assert and synchronous-edge release.
- Latency: result is visible the cycle after the accepting edge. Throughput is one load per cycle when `i_ready = 1`.
- Accept and drain in the same cycle: the new result replaces the old one with no bubble.
- Backpressure: `o_data_out` and `o_misaligned` are stable while `o_valid && !i_ready`.
- Reset during BEAT2: the held first beat is discarded. The next accepted beat is decoded as a new load.

## Configuration
- `LOAD_UNALIGNED_EN` defined:
  - Misaligned lanes that lie entirely within one word are extracted in one beat, with no fault.
  - When `offset + size > WORD_BYTES`:
    - Latch the upper bytes of beat 1, the op and the offset.
    - Go to BEAT2 and assert `o_beat2_pending`. `o_valid` is not raised.
    - On the next accepted beat, ignore its offset and op. Merge: beat-1 bytes [offset..WORD_BYTES-1] form the low bytes; beat-2 bytes [0..offset+size-WORD_BYTES-1] form the upper bytes.
    - Extend, load the output, return to IDLE and clear `o_beat2_pending`.
  - `o_misaligned` is never asserted.
- `LOAD_UNALIGNED_EN` undefined: alignment fault rule applies and BEAT2 is not synthesised. `o_beat2_pending` is tied 0.

## Test plan
- LB, offset 3, data 0x80AABBCC -> `o_data_out` = 0xFFFFFF80, `o_valid` one cycle after accept.
- LHU, offset 2, data 0x80011234 -> 0x00008001. Same beat as LH -> 0xFFFF8001.
- Backpressure: `i_ready` = 0 for 3 cycles with a result pending -> output held, `o_ready` = 0, second input not accepted until `i_ready` rises.
- Macro off: LW, offset 1 -> `o_misaligned` = 1, `o_data_out` = 0. Macro on: LH, offset 1, data 0x00CDAB00 -> 0xFFFFCDAB in one beat.
- Macro on: LW offset 3 with beat 1 = 0x11223344 -> `o_beat2_pending` = 1, `o_valid` = 0. Then beat 2 = 0x55667788 -> 0x66778811. PROC_BITS=64: LD offset 0 with 0x8000000000000001 -> same value.
- Macro on: assert `i_reset_n` = 0 in BEAT2 -> `o_beat2_pending` and `o_valid` clear immediately. A following LBU offset 0 with data 0x000000F0 -> 0x000000F0.
